// File: rtl/priority_drain_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// priority_drain_sequencer_pkg
//   Shared definitions for the priority drain sequencer and its coder:
//   mask/position widths and the sequencer state type.
// -----------------------------------------------------------------------------
package priority_drain_sequencer_pkg;

    localparam int unsigned PC_WIDTH = 16;
    localparam int unsigned PC_POS_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/priority_drain_sequencer_if.sv
// -----------------------------------------------------------------------------
// priority_drain_sequencer_if
//   Mask-in / position-out handshake bundle.
//     in_valid, in_ready, in_mask              : mask acceptance (valid/ready)
//     out_valid, out_ready, out_pos, out_last  : one position per beat
//     remaining                                : pending bits incl. current beat
//   master : producer of masks / consumer of positions
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface priority_drain_sequencer_if
    import priority_drain_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned POS_W = PC_POS_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_pos;
    logic             out_last;
    logic [POS_W:0]   remaining;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_pos, out_last, remaining
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_pos, out_last, remaining
    );
endinterface

// File: rtl/priority_drain_sequencer_coder.sv
// -----------------------------------------------------------------------------
// priority_coder_wire
//   Purely combinational lowest-set-bit encoder.
//     data     in  WIDTH  request vector
//     position out POS_W  index of the lowest set bit (0 when data is zero)
// -----------------------------------------------------------------------------
module priority_coder_wire
    import priority_drain_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned POS_W = PC_POS_W
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] position
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        position = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (data[i-1]) begin
                position = POS_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/priority_drain_sequencer.sv
// -----------------------------------------------------------------------------
// priority_drain_sequencer
//   Captures a request mask and emits each set bit's index, lowest first,
//   one per handshake beat, clearing each bit as it is served.
//     clk  in  rising-edge clock
//     rst  in  asynchronous active-high reset
//     bus  slave modport of priority_drain_sequencer_if
//   A new mask may be loaded in the same cycle as the final beat of the
//   previous one (combinational in_ready), giving gap-free streams.
// -----------------------------------------------------------------------------
module priority_drain_sequencer
    import priority_drain_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned POS_W = PC_POS_W
) (
    input  logic                          clk,
    input  logic                          rst,
    priority_drain_sequencer_if.slave     bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [POS_W-1:0] pos;
    logic [POS_W:0]   rem;
    logic             valid;
    logic             last;
    logic             ready;
    logic             fire;
    logic             load_nz;

    function automatic logic [POS_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [POS_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + (POS_W+1)'(v[i]);
        end
        return c;
    endfunction

    priority_coder_wire #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_coder (
        .data     (mask_q),
        .position (pos)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Output / handshake decode
    always_comb begin
        valid   = (state_q == ST_DRAIN);
        // A single remaining bit means clearing the lowest one leaves nothing.
        last    = valid && ((mask_q & (mask_q - WIDTH'(1))) == '0);
        rem     = valid ? popcount(mask_q) : '0;
        fire    = valid && bus.out_ready;
        ready   = !rst && (!valid || (fire && last));
        // A zero mask is accepted but never loaded: the coder cannot tell it
        // apart from a lone bit 0.
        load_nz = bus.in_valid && ready && (bus.in_mask != '0);
    end

    // Next-state / next-mask
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_nz) begin
                    mask_d  = bus.in_mask;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fire) begin
                    mask_d = mask_q & ~(WIDTH'(1) << pos);
                    if (last) begin
                        if (load_nz) begin
                            mask_d = bus.in_mask;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_pos   = pos;
    assign bus.out_last  = last;
    assign bus.remaining = rem;

endmodule

// File: tb/tb_priority_drain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_priority_drain_sequencer
//   Scoreboard bench: every accepted mask is expanded by a reference model
//   into its list of expected beats; an independent monitor pops and checks
//   each beat the DUT delivers.
// -----------------------------------------------------------------------------
module tb_priority_drain_sequencer;

    typedef struct {
        logic [3:0] pos;
        logic       last;
        logic [4:0] rem;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   beats_seen;
    int   ready_mode;
    exp_t sb[$];

    priority_drain_sequencer_if bus ();

    priority_drain_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list set bits ascending; remaining counts down to 1.
    task automatic push_expected(input logic [15:0] m);
        int   idx[$];
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) idx.push_back(i);
        end
        for (int k = 0; k < idx.size(); k++) begin
            e.pos  = 4'(idx[k]);
            e.last = (k == idx.size() - 1);
            e.rem  = 5'(idx.size() - k);
            sb.push_back(e);
        end
    endtask

    // Present a mask until accepted; b2b reports whether a beat was live then.
    task automatic send(input logic [15:0] m, output logic b2b);
        b2b = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mask  = m;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (bus.in_ready) begin
                push_expected(m);
                b2b = bus.out_valid;
                return;
            end
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: mask %04h never accepted", m);
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #3;
            n++;
            if (sb.size() == 0 && !bus.out_valid) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    endtask

    // Consumer readiness
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic       stalled;
        logic [3:0] hp;
        logic       hl;
        logic [4:0] hr;
        exp_t       e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_pos", bus.out_pos, hp);
                chk("hold_last", bus.out_last, hl);
                chk("hold_remaining", bus.remaining, hr);
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    beats_seen++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL extra_beat: got pos %0d, required no beat", bus.out_pos);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_pos", bus.out_pos, e.pos);
                        chk("beat_last", bus.out_last, e.last);
                        chk("beat_remaining", bus.remaining, e.rem);
                    end
                end else begin
                    stalled = 1'b1;
                    hp = bus.out_pos;
                    hl = bus.out_last;
                    hr = bus.remaining;
                end
            end else begin
                chk("idle_remaining", bus.remaining, 0);
                chk("idle_last", bus.out_last, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic       b;
        int         n;
        int         base;
        bit         hit;
        logic [15:0] m;

        n_cmp      = 0;
        n_fail     = 0;
        beats_seen = 0;
        ready_mode = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pos", bus.out_pos, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("idle_in_ready", bus.in_ready, 1);

        // 1: two sparse bits
        send(16'h0022, b);
        drain(n);
        chk("t1_cycles", n, 3);

        // 2: full mask, 16 gap-free beats
        send(16'hFFFF, b);
        drain(n);
        chk("t2_cycles", n, 17);

        // 3: zero mask accepted and discarded
        send(16'h0000, b);
        chk("t3_no_beat_live", b, 0);
        drain(n);
        chk("t3_cycles", n, 1);

        // 4: stall with out_ready low
        ready_mode = 2;
        send(16'h8001, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) begin
            #3;
            chk("t4_valid", bus.out_valid, 1);
            chk("t4_pos", bus.out_pos, 0);
            chk("t4_remaining", bus.remaining, 2);
            @(negedge clk);
        end
        #1;
        ready_mode = 0;
        drain(n);

        // 5: back-to-back load on the last beat
        send(16'h0100, b);
        send(16'h0010, b);
        chk("t5_back_to_back", b, 1);
        drain(n);
        chk("t5_cycles", n, 2);

        // 6: reset mid-drain loses pending bits
        base = beats_seen;
        send(16'h00F0, b);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #3;
            if (beats_seen >= base + 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_two_beats_seen", hit, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_remaining", bus.remaining, 0);
        chk("t6_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("t6_post_in_ready", bus.in_ready, 1);
        chk("t6_post_valid", bus.out_valid, 0);
        drain(n);
        chk("t6_cycles", n, 1);

        // Random masks with random back-pressure and gaps
        ready_mode = 1;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            case ($urandom_range(0, 5))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                2:       m = 16'(1 << $urandom_range(0, 15));
                3:       m = 16'($urandom) & 16'($urandom);
                default: m = 16'($urandom);
            endcase
            send(m, b);
        end
        drain(n);
        chk("final_queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
